// File: rtl/mfcc_melbank_pkg.sv
// mfcc_melbank_pkg
// Shared definitions for the mel-filterbank controller:
//   - melbank_state_e : controller FSM states
//   - DEF_*           : default parameter widths
//   - ROM word layout : {last, bin, weight}. The weight sits in the LSBs,
//                       the bin is above it and the last flag is the MSB.
//                       Use the helper functions to locate the fields.
package mfcc_melbank_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH_W = 3'd1,
        FETCH_S = 3'd2,
        MAC     = 3'd3,
        EMIT    = 3'd4,
        DONE    = 3'd5
    } melbank_state_e;

    localparam int DEF_ROM_AW      = 10;
    localparam int DEF_BIN_AW      = 9;
    localparam int DEF_WGT_WIDTH   = 16;
    localparam int DEF_SPEC_WIDTH  = 32;
    localparam int DEF_ACC_WIDTH   = 48;
    localparam int DEF_NUM_ENTRIES = 512;
    localparam int DEF_FILT_W      = 5;

    // Weight field starts at bit 0 of the ROM word.
    localparam int WGT_LSB = 0;

    // Bin field sits directly above the weight.
    function automatic int bin_lsb(input int wgt_width);
        return WGT_LSB + wgt_width;
    endfunction

    // Last flag is the MSB, directly above the bin.
    function automatic int last_bit(input int wgt_width, input int bin_aw);
        return WGT_LSB + wgt_width + bin_aw;
    endfunction

endpackage

// File: rtl/mfcc_melbank_mac.sv
// mfcc_melbank_mac
// Unsigned multiply-accumulate for the mel-filterbank controller.
// Optional feature macro: MELBANK_SAT_EN. When it is defined, the
// accumulator clamps at all-ones and holds there until cleared. Otherwise
// the accumulator wraps modulo 2**ACC_WIDTH.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   clr      : synchronous clear of the accumulator (has priority over en)
//   en       : add a*b to the accumulator this cycle
//   a, b     : unsigned operands (spectrum sample, filter weight)
//   acc      : registered accumulator value
module mfcc_melbank_mac #(
    parameter int A_W       = 32,
    parameter int B_W       = 16,
    parameter int ACC_WIDTH = 48
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic [A_W-1:0]       a,
    input  logic [B_W-1:0]       b,
    output logic [ACC_WIDTH-1:0] acc
);

    localparam int PROD_W = A_W + B_W;

    logic [PROD_W-1:0]    prod;
    logic [ACC_WIDTH-1:0] acc_nxt;

`ifdef MELBANK_SAT_EN
    // One extra bit above the wider of the two addends catches any carry-out.
    localparam int SUM_W = ((ACC_WIDTH > PROD_W) ? ACC_WIDTH : PROD_W) + 1;
    logic [SUM_W-1:0] sum;

    // Full-width sum; any set bit above ACC_WIDTH means overflow, so clamp.
    always_comb begin
        prod = a * b;
        sum  = SUM_W'(acc) + SUM_W'(prod);
        if (sum[SUM_W-1:ACC_WIDTH] != '0) begin
            acc_nxt = '1;
        end else begin
            acc_nxt = sum[ACC_WIDTH-1:0];
        end
    end
`else
    // Wrapping sum: the product is truncated to the accumulator width.
    always_comb begin
        prod    = a * b;
        acc_nxt = acc + ACC_WIDTH'(prod);
    end
`endif

    // Accumulator register. Clear wins over enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_nxt;
        end else begin
            acc <= acc;
        end
    end

endmodule

// File: rtl/mfcc_melbank_ctrl.sv
// mfcc_melbank_ctrl
// Walks the melbank ROM once per frame. Each entry takes three cycles:
// FETCH_W reads the ROM, FETCH_S reads the spectrum, and MAC accumulates
// spectrum*weight. An entry with last=1 closes a filter, and its energy is
// offered on a valid/ready output.
// Optional feature macro: MELBANK_SAT_EN (saturating accumulator, see mac).
// Ports:
//   clk, rst      : clock and asynchronous active-high reset
//   start, busy   : frame start pulse (ignored while busy) and frame-in-progress flag
//   done          : one-cycle end-of-frame pulse
//   rom_addr      : ROM read address
//   rom_rd_data   : ROM read data {last, bin, weight}, 1-cycle latency
//   spec_addr     : spectrum read address
//   spec_rd_data  : spectrum read data, 1-cycle latency
//   out_valid, out_ready, out_data, out_filt : filter energy stream
module mfcc_melbank_ctrl
    import mfcc_melbank_pkg::*;
#(
    parameter int ROM_AW      = DEF_ROM_AW,
    parameter int BIN_AW      = DEF_BIN_AW,
    parameter int WGT_WIDTH   = DEF_WGT_WIDTH,
    parameter int SPEC_WIDTH  = DEF_SPEC_WIDTH,
    parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
    parameter int NUM_ENTRIES = DEF_NUM_ENTRIES,
    parameter int FILT_W      = DEF_FILT_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [ROM_AW-1:0]             rom_addr,
    input  logic [BIN_AW+WGT_WIDTH:0]     rom_rd_data,
    output logic [BIN_AW-1:0]             spec_addr,
    input  logic [SPEC_WIDTH-1:0]         spec_rd_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ACC_WIDTH-1:0]          out_data,
    output logic [FILT_W-1:0]             out_filt
);

    localparam int BIN_LSB  = bin_lsb(WGT_WIDTH);
    localparam int LAST_BIT = last_bit(WGT_WIDTH, BIN_AW);
    localparam logic [ROM_AW-1:0] LAST_ENTRY = ROM_AW'(NUM_ENTRIES - 1);

    melbank_state_e state, state_nxt;

    logic [ROM_AW-1:0]    entry, entry_nxt;
    logic [FILT_W-1:0]    filt, filt_nxt;
    logic [ROM_AW-1:0]    rom_addr_nxt;
    logic                 busy_nxt, done_nxt, valid_nxt;
    logic                 capture, acc_clr, acc_en;
    logic [WGT_WIDTH-1:0] wgt_r;
    logic [BIN_AW-1:0]    bin_r;
    logic                 last_r;
    logic [BIN_AW-1:0]    rom_bin;
    logic [ACC_WIDTH-1:0] acc;

    assign rom_bin = rom_rd_data[BIN_LSB +: BIN_AW];

    // The spectrum read must be issued in the same cycle the ROM word arrives,
    // so the bin is forwarded straight from the ROM during FETCH_S.
    assign spec_addr = (state == FETCH_S) ? rom_bin : bin_r;
    assign out_data  = acc;
    assign out_filt  = filt;

    // Next-state and control decode.
    always_comb begin
        state_nxt    = state;
        entry_nxt    = entry;
        filt_nxt     = filt;
        rom_addr_nxt = rom_addr;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        valid_nxt    = out_valid;
        capture      = 1'b0;
        acc_clr      = 1'b0;
        acc_en       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    entry_nxt    = '0;
                    filt_nxt     = '0;
                    rom_addr_nxt = '0;
                    acc_clr      = 1'b1;
                    busy_nxt     = 1'b1;
                    state_nxt    = FETCH_W;
                end else begin
                    state_nxt = IDLE;
                end
            end
            FETCH_W: begin
                state_nxt = FETCH_S;
            end
            FETCH_S: begin
                capture   = 1'b1;
                state_nxt = MAC;
            end
            MAC: begin
                acc_en = 1'b1;
                if (last_r) begin
                    valid_nxt = 1'b1;
                    state_nxt = EMIT;
                end else if (entry == LAST_ENTRY) begin
                    // Trailing entries without a last flag are dropped.
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end else begin
                    entry_nxt    = entry + ROM_AW'(1);
                    rom_addr_nxt = entry + ROM_AW'(1);
                    state_nxt    = FETCH_W;
                end
            end
            EMIT: begin
                if (out_valid && out_ready) begin
                    valid_nxt = 1'b0;
                    acc_clr   = 1'b1;
                    filt_nxt  = filt + FILT_W'(1);
                    if (entry == LAST_ENTRY) begin
                        done_nxt  = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        entry_nxt    = entry + ROM_AW'(1);
                        rom_addr_nxt = entry + ROM_AW'(1);
                        state_nxt    = FETCH_W;
                    end
                end else begin
                    state_nxt = EMIT;
                end
            end
            DONE: begin
                // busy stays high through DONE so a start here is ignored.
                busy_nxt  = 1'b0;
                acc_clr   = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, index and registered-output update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            entry     <= '0;
            filt      <= '0;
            rom_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            entry     <= entry_nxt;
            filt      <= filt_nxt;
            rom_addr  <= rom_addr_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            out_valid <= valid_nxt;
        end
    end

    // Capture of the ROM word fields for the following MAC cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wgt_r  <= '0;
            bin_r  <= '0;
            last_r <= 1'b0;
        end else if (capture) begin
            wgt_r  <= rom_rd_data[WGT_LSB +: WGT_WIDTH];
            bin_r  <= rom_bin;
            last_r <= rom_rd_data[LAST_BIT];
        end else begin
            wgt_r  <= wgt_r;
            bin_r  <= bin_r;
            last_r <= last_r;
        end
    end

    mfcc_melbank_mac #(
        .A_W       (SPEC_WIDTH),
        .B_W       (WGT_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (acc_clr),
        .en  (acc_en),
        .a   (spec_rd_data),
        .b   (wgt_r),
        .acc (acc)
    );

endmodule

// File: tb/tb_mfcc_melbank_ctrl.sv
// tb_mfcc_melbank_ctrl
// Directed bench for mfcc_melbank_ctrl. It uses a 4-entry frame on the default
// widths, plus a second instance with an 8-bit accumulator for overflow.
module tb_mfcc_melbank_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Main instance: NUM_ENTRIES=4, default widths.
    logic        start, busy, done, out_valid, out_ready;
    logic [9:0]  rom_addr;
    logic [25:0] rom_rd_data;
    logic [8:0]  spec_addr;
    logic [31:0] spec_rd_data;
    logic [47:0] out_data;
    logic [4:0]  out_filt;

    logic [25:0] rom  [0:1023];
    logic [31:0] spec [0:511];

    mfcc_melbank_ctrl #(.NUM_ENTRIES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rom_addr(rom_addr), .rom_rd_data(rom_rd_data),
        .spec_addr(spec_addr), .spec_rd_data(spec_rd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_filt(out_filt)
    );

    always @(posedge clk) begin
        rom_rd_data  <= rom[rom_addr];
        spec_rd_data <= spec[spec_addr];
    end

    // Overflow instance: ACC_WIDTH=8, one entry.
    logic        b_start, b_busy, b_done, b_out_valid;
    logic        b_out_ready = 1'b1;
    logic [9:0]  b_rom_addr;
    logic [25:0] b_rom_rd_data;
    logic [8:0]  b_spec_addr;
    logic [31:0] b_spec_rd_data;
    logic [31:0] b_spec0;
    logic [7:0]  b_out_data;
    logic [4:0]  b_out_filt;

    mfcc_melbank_ctrl #(.ACC_WIDTH(8), .NUM_ENTRIES(1)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
        .rom_addr(b_rom_addr), .rom_rd_data(b_rom_rd_data),
        .spec_addr(b_spec_addr), .spec_rd_data(b_spec_rd_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_filt(b_out_filt)
    );

    always @(posedge clk) begin
        b_rom_rd_data  <= (b_rom_addr == 10'd0) ? {1'b1, 9'd0, 16'd255} : 26'd0;
        b_spec_rd_data <= (b_spec_addr == 9'd0) ? b_spec0 : 32'd0;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [25:0] mkw(input logic last, input int bin, input int wgt);
        logic [8:0]  b9;
        logic [15:0] w16;
        b9  = bin[8:0];
        w16 = wgt[15:0];
        return {last, b9, w16};
    endfunction

    // Results of the most recent run_frame.
    logic [47:0] res_data [0:3];
    logic [4:0]  res_filt [0:3];
    int n_res, n_done, done_cyc, vcount;

    // Runs one frame. cyc counts posedges after the edge that samples start.
    task automatic run_frame(input int stall, input int restart_at);
        int cyc;
        n_res = 0; n_done = 0; done_cyc = -1; vcount = 0;
        @(negedge clk);
        start = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        cyc = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            start = (cyc == restart_at);
            if (out_valid) begin
                if (n_res == 0 && vcount < stall) begin
                    out_ready = 1'b0;
                    check("stall_data", out_data, 64'd80);
                    check("stall_rom_addr", rom_addr, 64'd1);
                    vcount++;
                end else begin
                    out_ready = 1'b1;
                    if (n_res < 4) begin
                        res_data[n_res] = out_data;
                        res_filt[n_res] = out_filt;
                    end
                    n_res++;
                end
            end else begin
                out_ready = 1'b1;
            end
            if (done) begin
                if (n_done == 0) done_cyc = cyc;
                n_done++;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
            @(posedge clk);
            cyc++;
        end
        start = 1'b0; out_ready = 1'b1;
    endtask

    task automatic check_two(input string tag, input int exp_done);
        check({tag, "_n_res"}, n_res, 64'd2);
        check({tag, "_data0"}, res_data[0], 64'd80);
        check({tag, "_filt0"}, res_filt[0], 64'd0);
        check({tag, "_data1"}, res_data[1], 64'd190);
        check({tag, "_filt1"}, res_filt[1], 64'd1);
        check({tag, "_done_cyc"}, done_cyc, exp_done);
        check({tag, "_n_done"}, n_done, 64'd1);
        check({tag, "_busy_end"}, busy, 64'd0);
    endtask

    task automatic run_small(input logic [31:0] sval, input logic [7:0] exp);
        int got;
        int seen_done;
        got = 0; seen_done = 0;
        b_spec0 = sval;
        @(negedge clk); b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (b_out_valid && got == 0) begin
                check("small_data", b_out_data, exp);
                check("small_filt", b_out_filt, 64'd0);
                got = 1;
            end
            if (b_done) seen_done = 1;
            @(negedge clk);
        end
        check("small_valid_seen", got, 64'd1);
        check("small_done_seen", seen_done, 64'd1);
    endtask

    initial begin
        int nv, nd;
        rst = 1'b1; start = 1'b0; out_ready = 1'b1; b_start = 1'b0; b_spec0 = 32'd0;
        for (int i = 0; i < 1024; i++) rom[i] = 26'd0;
        for (int i = 0; i < 512; i++) spec[i] = 32'(10 * i);
        rom[0] = mkw(1'b0, 1, 2);
        rom[1] = mkw(1'b1, 2, 3);
        rom[2] = mkw(1'b0, 3, 1);
        rom[3] = mkw(1'b1, 4, 4);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_busy", busy, 64'd0);
        check("rst_done", done, 64'd0);
        check("rst_valid", out_valid, 64'd0);
        check("rst_rom_addr", rom_addr, 64'd0);
        check("rst_spec_addr", spec_addr, 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_filt", out_filt, 64'd0);

        // Basic frame with ready always high.
        run_frame(0, -1);
        check_two("basic", 14);

        // Back-pressure for 5 cycles at the first EMIT.
        run_frame(5, -1);
        check("stall_cycles", vcount, 64'd5);
        check_two("stall", 19);

        // A start during FETCH_S of entry 2 must be ignored.
        run_frame(0, 8);
        check_two("restart", 14);

        // Reset during MAC of entry 1 abandons the frame.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_rom_addr_pre", rom_addr, 64'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 64'd0);
        check("abort_valid", out_valid, 64'd0);
        check("abort_rom_addr", rom_addr, 64'd0);
        check("abort_out_data", out_data, 64'd0);
        @(negedge clk); rst = 1'b0;
        nv = 0; nd = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) nv++;
            if (done) nd++;
        end
        check("abort_no_valid", nv, 64'd0);
        check("abort_no_done", nd, 64'd0);
        run_frame(0, -1);
        check_two("after_abort", 14);

        // A final entry without last discards its partial sum.
        rom[3] = mkw(1'b0, 4, 4);
        run_frame(0, -1);
        check("nolast_n_res", n_res, 64'd1);
        check("nolast_data0", res_data[0], 64'd80);
        check("nolast_done_cyc", done_cyc, 64'd13);
        check("nolast_n_done", n_done, 64'd1);
        rom[3] = mkw(1'b1, 4, 4);

        // Accumulator overflow on the 8-bit instance.
`ifdef MELBANK_SAT_EN
        run_small(32'd2, 8'd255);
        run_small(32'd3, 8'd255);
`else
        run_small(32'd2, 8'd254);
        run_small(32'd3, 8'd253);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mfcc_melbank_ctrl.md
MFCC_MELBANK_CTRL -- requirements
Module: mfcc_melbank_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning), one per line:
  ROM_AW       10   melbank ROM address width
  BIN_AW       9    spectrum-buffer address width
  WGT_WIDTH    16   unsigned filter weight width
  SPEC_WIDTH   32   unsigned power-spectrum sample width
  ACC_WIDTH    48   accumulator and output width
  NUM_ENTRIES  512  ROM entries walked per frame, 1..2**ROM_AW
  FILT_W       5    filter index width
REQ-002 Ports SHALL be (name, direction, width, meaning), one per line:
  clk          in   1                        single clock
  rst          in   1                        asynchronous reset, active-high
  start        in   1                        frame start pulse
  busy         out  1                        frame in progress
  done         out  1                        one-cycle pulse at end of frame
  rom_addr     out  ROM_AW                   melbank ROM address
  rom_rd_data  in   1+BIN_AW+WGT_WIDTH       ROM word {last, bin, weight}; registered ROM, 1-cycle latency
  spec_addr    out  BIN_AW                   spectrum buffer address
  spec_rd_data in   SPEC_WIDTH               spectrum sample, 1-cycle latency
  out_valid    out  1                        filter energy valid
  out_ready    in   1                        downstream accepts
  out_data     out  ACC_WIDTH                filter energy
  out_filt     out  FILT_W                   filter index of out_data

Function
REQ-003 FSM states SHALL be IDLE, FETCH_W, FETCH_S, MAC, EMIT, DONE.
REQ-004 IDLE: start=1 SHALL clear entry index, filter index and accumulator, set busy, and go to FETCH_W.
REQ-005 FETCH_W SHALL drive rom_addr=entry index for one cycle, then go to FETCH_S.
REQ-006 FETCH_S SHALL capture weight, bin and last from rom_rd_data, drive spec_addr=bin, then go to MAC.
REQ-007 MAC SHALL add spec_rd_data*weight (full-width unsigned product, zero-extended to ACC_WIDTH) to the accumulator.
REQ-008 From MAC the FSM SHALL go to EMIT if last=1; else to DONE if entry index = NUM_ENTRIES-1; else increment the entry index and go to FETCH_W.
REQ-009 Each ROM entry SHALL take exactly 3 cycles (FETCH_W, FETCH_S, MAC).
REQ-010 EMIT SHALL assert out_valid with out_data=accumulator and out_filt=filter index, holding both stable until out_valid&&out_ready.
REQ-011 On an EMIT handshake the block SHALL clear the accumulator, increment the filter index (wrapping modulo 2**FILT_W), then go to DONE if entry index = NUM_ENTRIES-1, else increment the entry index and go to FETCH_W.
REQ-012 DONE SHALL pulse done for one cycle, deassert busy, and return to IDLE.
REQ-013 start SHALL be ignored while busy=1, including in the DONE cycle.
REQ-014 A final entry with last=0 SHALL discard its partial accumulation, with no out_valid.
REQ-015 Without the saturation feature, the accumulator SHALL wrap modulo 2**ACC_WIDTH.

Reset
REQ-016 rst=1 SHALL asynchronously force: IDLE; busy, done and out_valid to 0; rom_addr, spec_addr, out_data, out_filt, accumulator and indices to 0.
REQ-017 rst asserted mid-frame SHALL abandon the frame with no done pulse; the next start after rst deasserts SHALL begin a fresh frame at entry 0.

Configuration
REQ-018 With MELBANK_SAT_EN defined, the accumulator SHALL clamp at 2**ACC_WIDTH-1 on overflow and hold that value until cleared.
REQ-019 Without MELBANK_SAT_EN, the accumulator SHALL wrap per REQ-015, and no clamp logic SHALL be present.

Structure
REQ-020 Package mfcc_melbank_pkg SHALL hold the state enum, the ROM-word field offset constants (weight LSBs, then bin, then last at the MSB) and the default widths.
REQ-021 Sub-module mfcc_melbank_mac SHALL implement the multiply-accumulate with clear, enable and the MELBANK_SAT_EN clamp; the FSM and addressing stay in mfcc_melbank_ctrl.

Verification
REQ-022 NUM_ENTRIES=4; entries (bin,weight,last) = (1,2,0),(2,3,1),(3,1,0),(4,4,1); spec[n]=10*n; out_ready=1 -> out_data 80 with out_filt 0, then 190 with out_filt 1; done 1 cycle after the second handshake; 14 cycles start-to-done.
REQ-023 Same frame with out_ready=0 for 5 cycles at the first EMIT -> out_valid and out_data=80 held stable for 5 cycles; rom_addr unchanged; second result unaffected.
REQ-024 start pulsed again during FETCH_S of entry 2 -> ignored, with identical outputs to REQ-022.
REQ-025 rst pulsed during MAC of entry 1, then start -> no out_valid or done from the aborted frame; new frame gives 80 then 190.
REQ-026 ACC_WIDTH=8, one entry (bin 0, weight 255, last 1), spec[0]=2 -> out_data 254; same with weight 255, spec 3 -> 255 with MELBANK_SAT_EN, 253 without.
